// File: rtl/core_regbank_pkg.sv
// Shared constants and helpers for the architectural register bank.
package core_regbank_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic FILE_INT = 1'b0;
  localparam logic FILE_FP  = 1'b1;

  // Number of index bits needed to address nreg registers (nreg is a power of 2).
  function automatic int aw_of(input int nreg);
    int aw;
    aw = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < nreg) begin
        aw = i + 1;
      end
    end
    return aw;
  endfunction

endpackage

// File: rtl/core_regbank_file.sv
// One register file: storage, per-register busy bits, lane-merged writes and
// combinational next-state read taps used for same-cycle bypass.
module core_regbank_file
  import core_regbank_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int NRP      = 2,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [AW-1:0]       w_addr,
  input  logic [XLEN-1:0]     w_data,
  input  logic [XLEN/8-1:0]   w_be,
  input  logic                w_done,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                flush,
  input  logic [NRP*AW-1:0]   r_addr,
  output logic [NRP*XLEN-1:0] r_data_nxt,
  output logic [NRP-1:0]      r_busy_nxt
);

  localparam int LANES = XLEN / 8;

  logic [XLEN-1:0] mem_r      [NREG];
  logic [NREG-1:0] busy_r;
  logic [XLEN-1:0] mem_nxt_s  [NREG];
  logic [NREG-1:0] busy_nxt_s;

  // Next-state of every register: lane merge, busy set/clear/flush, zero register.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      mem_nxt_s[i]  = mem_r[i];
      busy_nxt_s[i] = busy_r[i];
      if (ZERO_REG && (i == 0)) begin
        mem_nxt_s[i]  = '0;
        busy_nxt_s[i] = 1'b0;
      end else begin
        if (w_en && (w_addr == AW'(i))) begin
          for (int l = 0; l < LANES; l++) begin
            if (w_be[l]) begin
              mem_nxt_s[i][8*l +: 8] = w_data[8*l +: 8];
            end else begin
              mem_nxt_s[i][8*l +: 8] = mem_r[i][8*l +: 8];
            end
          end
        end else begin
          mem_nxt_s[i] = mem_r[i];
        end
        // A new issue outranks the completing write: the register has a fresh producer.
        if (flush) begin
          busy_nxt_s[i] = 1'b0;
        end else if (sb_set && (sb_addr == AW'(i))) begin
          busy_nxt_s[i] = 1'b1;
        end else if (w_en && w_done && (w_addr == AW'(i))) begin
          busy_nxt_s[i] = 1'b0;
        end else begin
          busy_nxt_s[i] = busy_r[i];
        end
      end
    end
  end

  // Read taps see the post-write state so a same-cycle write is bypassed.
  always_comb begin
    r_data_nxt = '0;
    r_busy_nxt = '0;
    for (int p = 0; p < NRP; p++) begin
      r_data_nxt[p*XLEN +: XLEN] = mem_nxt_s[r_addr[p*AW +: AW]];
      r_busy_nxt[p]              = busy_nxt_s[r_addr[p*AW +: AW]];
    end
  end

  // Storage and busy state update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= '0;
      end
      busy_r <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/core_regbank.sv
// Integer/FP architectural register bank with pending-write scoreboard and PC.
module core_regbank
  import core_regbank_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int NREG    = 32,
  parameter int NRP     = 2,
  parameter bit F0_ZERO = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         W_VALID,
  input  logic                         W_FP,
  input  logic [aw_of(NREG)-1:0]       W_ADDR,
  input  logic [XLEN-1:0]              W_DATA,
  input  logic [XLEN/8-1:0]            W_BE,
  input  logic                         W_DONE,
  input  logic                         SB_SET,
  input  logic                         SB_FP,
  input  logic [aw_of(NREG)-1:0]       SB_ADDR,
  input  logic                         FLUSH,
  input  logic [NRP-1:0]               R_FP,
  input  logic [NRP*aw_of(NREG)-1:0]   R_ADDR,
  output logic [NRP*XLEN-1:0]          R_DATA,
  output logic [NRP-1:0]               R_BUSY,
  input  logic                         PC_WE,
  input  logic [XLEN-1:0]              PC_WDATA,
  output logic [XLEN-1:0]              PC
);

  localparam int AW = aw_of(NREG);

  logic [NRP*XLEN-1:0] int_data_s;
  logic [NRP*XLEN-1:0] fp_data_s;
  logic [NRP-1:0]      int_busy_s;
  logic [NRP-1:0]      fp_busy_s;
  logic [NRP*XLEN-1:0] rd_data_s;
  logic [NRP-1:0]      rd_busy_s;

  core_regbank_file #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .AW(AW), .ZERO_REG(1'b1)
  ) u_int_file (
    .clk        (CLK),
    .rst        (RST),
    .w_en       (W_VALID && (W_FP == FILE_INT)),
    .w_addr     (W_ADDR),
    .w_data     (W_DATA),
    .w_be       (W_BE),
    .w_done     (W_DONE),
    .sb_set     (SB_SET && (SB_FP == FILE_INT)),
    .sb_addr    (SB_ADDR),
    .flush      (FLUSH),
    .r_addr     (R_ADDR),
    .r_data_nxt (int_data_s),
    .r_busy_nxt (int_busy_s)
  );

  core_regbank_file #(
    .XLEN(XLEN), .NREG(NREG), .NRP(NRP), .AW(AW), .ZERO_REG(F0_ZERO)
  ) u_fp_file (
    .clk        (CLK),
    .rst        (RST),
    .w_en       (W_VALID && (W_FP == FILE_FP)),
    .w_addr     (W_ADDR),
    .w_data     (W_DATA),
    .w_be       (W_BE),
    .w_done     (W_DONE),
    .sb_set     (SB_SET && (SB_FP == FILE_FP)),
    .sb_addr    (SB_ADDR),
    .flush      (FLUSH),
    .r_addr     (R_ADDR),
    .r_data_nxt (fp_data_s),
    .r_busy_nxt (fp_busy_s)
  );

  // Per-port file select.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int p = 0; p < NRP; p++) begin
      if (R_FP[p] == FILE_FP) begin
        rd_data_s[p*XLEN +: XLEN] = fp_data_s[p*XLEN +: XLEN];
        rd_busy_s[p]              = fp_busy_s[p];
      end else begin
        rd_data_s[p*XLEN +: XLEN] = int_data_s[p*XLEN +: XLEN];
        rd_busy_s[p]              = int_busy_s[p];
      end
    end
  end

  // Registered read outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_DATA <= '0;
      R_BUSY <= '0;
    end else begin
      R_DATA <= rd_data_s;
      R_BUSY <= rd_busy_s;
    end
  end

  // Program counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC <= '0;
    end else if (PC_WE) begin
      PC <= PC_WDATA;
    end else begin
      PC <= PC;
    end
  end

endmodule

// File: tb/tb_core_regbank.sv
// Scoreboard bench for core_regbank: default configuration plus a 64-bit/16-reg/3-port sweep.
module tb_core_regbank;

  logic CLK = 1'b0;
  logic RST;

  // Default configuration DUT
  logic        W_VALID, W_FP, W_DONE, SB_SET, SB_FP, FLUSH, PC_WE;
  logic [4:0]  W_ADDR, SB_ADDR;
  logic [31:0] W_DATA, PC_WDATA, PC;
  logic [3:0]  W_BE;
  logic [1:0]  R_FP, R_BUSY;
  logic [9:0]  R_ADDR;
  logic [63:0] R_DATA;

  // Swept configuration DUT
  logic         b_w_valid, b_w_fp, b_w_done, b_sb_set, b_sb_fp, b_flush, b_pc_we;
  logic [3:0]   b_w_addr, b_sb_addr;
  logic [63:0]  b_w_data, b_pc_wdata, b_pc;
  logic [7:0]   b_w_be;
  logic [2:0]   b_r_fp, b_r_busy;
  logic [11:0]  b_r_addr;
  logic [191:0] b_r_data;

  core_regbank dut (
    .CLK(CLK), .RST(RST), .W_VALID(W_VALID), .W_FP(W_FP), .W_ADDR(W_ADDR),
    .W_DATA(W_DATA), .W_BE(W_BE), .W_DONE(W_DONE), .SB_SET(SB_SET), .SB_FP(SB_FP),
    .SB_ADDR(SB_ADDR), .FLUSH(FLUSH), .R_FP(R_FP), .R_ADDR(R_ADDR), .R_DATA(R_DATA),
    .R_BUSY(R_BUSY), .PC_WE(PC_WE), .PC_WDATA(PC_WDATA), .PC(PC)
  );

  core_regbank #(.XLEN(64), .NREG(16), .NRP(3), .F0_ZERO(1'b0)) dut_b (
    .CLK(CLK), .RST(RST), .W_VALID(b_w_valid), .W_FP(b_w_fp), .W_ADDR(b_w_addr),
    .W_DATA(b_w_data), .W_BE(b_w_be), .W_DONE(b_w_done), .SB_SET(b_sb_set), .SB_FP(b_sb_fp),
    .SB_ADDR(b_sb_addr), .FLUSH(b_flush), .R_FP(b_r_fp), .R_ADDR(b_r_addr), .R_DATA(b_r_data),
    .R_BUSY(b_r_busy), .PC_WE(b_pc_we), .PC_WDATA(b_pc_wdata), .PC(b_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t  exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  string cur_tag;

  // Reference state of the default DUT
  logic [31:0] im[32];
  logic [31:0] fm[32];
  logic [31:0] ib, fb;
  logic [31:0] pc_m;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      im[i] = 32'd0;
      fm[i] = 32'd0;
    end
    ib   = 32'd0;
    fb   = 32'd0;
    pc_m = 32'd0;
  endtask

  task automatic idle_a();
    W_VALID = 1'b0; W_FP = 1'b0; W_ADDR = 5'd0; W_DATA = 32'd0; W_BE = 4'd0; W_DONE = 1'b0;
    SB_SET = 1'b0; SB_FP = 1'b0; SB_ADDR = 5'd0; FLUSH = 1'b0;
    R_FP = 2'd0; R_ADDR = 10'd0; PC_WE = 1'b0; PC_WDATA = 32'd0;
  endtask

  task automatic idle_b();
    b_w_valid = 1'b0; b_w_fp = 1'b0; b_w_addr = 4'd0; b_w_data = 64'd0; b_w_be = 8'd0;
    b_w_done = 1'b0; b_sb_set = 1'b0; b_sb_fp = 1'b0; b_sb_addr = 4'd0; b_flush = 1'b0;
    b_r_fp = 3'd0; b_r_addr = 12'd0; b_pc_we = 1'b0; b_pc_wdata = 64'd0;
  endtask

  task automatic rd(input int p, input logic fp, input logic [4:0] a);
    R_FP[p]          = fp;
    R_ADDR[p*5 +: 5] = a;
  endtask

  task automatic wr(input logic fp, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] be, input logic done);
    W_VALID = 1'b1; W_FP = fp; W_ADDR = a; W_DATA = d; W_BE = be; W_DONE = done;
  endtask

  task automatic sb(input logic fp, input logic [4:0] a);
    SB_SET = 1'b1; SB_FP = fp; SB_ADDR = a;
  endtask

  // One clock of the default DUT: predict, push, clock, pop and compare.
  task automatic cycle_a();
    logic [31:0] nim[32];
    logic [31:0] nfm[32];
    logic [31:0] nib, nfb, npc;
    logic [4:0]  a;
    nim = im; nfm = fm; nib = ib; nfb = fb; npc = pc_m;
    if (W_VALID) begin
      for (int l = 0; l < 4; l++) begin
        if (W_BE[l]) begin
          if (W_FP) nfm[W_ADDR][8*l +: 8] = W_DATA[8*l +: 8];
          else      nim[W_ADDR][8*l +: 8] = W_DATA[8*l +: 8];
        end
      end
      if (W_DONE) begin
        if (W_FP) nfb[W_ADDR] = 1'b0;
        else      nib[W_ADDR] = 1'b0;
      end
    end
    if (SB_SET) begin
      if (SB_FP) nfb[SB_ADDR] = 1'b1;
      else       nib[SB_ADDR] = 1'b1;
    end
    if (FLUSH) begin
      nib = 32'd0;
      nfb = 32'd0;
    end
    nim[0] = 32'd0; nfm[0] = 32'd0; nib[0] = 1'b0; nfb[0] = 1'b0;
    if (PC_WE) npc = PC_WDATA;
    for (int p = 0; p < 2; p++) begin
      a = R_ADDR[p*5 +: 5];
      push($sformatf("%s.p%0d.data", cur_tag, p), {32'd0, (R_FP[p] ? nfm[a] : nim[a])});
      push($sformatf("%s.p%0d.busy", cur_tag, p), {63'd0, (R_FP[p] ? nfb[a] : nib[a])});
    end
    push($sformatf("%s.pc", cur_tag), {32'd0, npc});
    @(posedge CLK);
    im = nim; fm = nfm; ib = nib; fb = nfb; pc_m = npc;
    #1;
    pop_check({32'd0, R_DATA[31:0]});
    pop_check({63'd0, R_BUSY[0]});
    pop_check({32'd0, R_DATA[63:32]});
    pop_check({63'd0, R_BUSY[1]});
    pop_check({32'd0, PC});
    idle_a();
  endtask

  initial begin
    idle_a();
    idle_b();
    model_reset();
    RST = 1'b1;
    #2;
    check_eq("rst.pc", {32'd0, PC}, 64'd0);
    check_eq("rst.rdata", R_DATA, 64'd0);
    check_eq("rst.rbusy", {62'd0, R_BUSY}, 64'd0);
    #2;
    RST = 1'b0;

    // Every integer register and f1 read zero after reset
    for (int i = 0; i < 32; i++) begin
      cur_tag = $sformatf("zero.x%0d", i);
      rd(0, 1'b0, 5'(i));
      rd(1, 1'b1, 5'd1);
      cycle_a();
    end

    // x0 ignores writes
    cur_tag = "x0_wr"; wr(1'b0, 5'd0, 32'hDEADBEEF, 4'hF, 1'b0); rd(0, 1'b0, 5'd0); cycle_a();
    cur_tag = "x0_rd"; rd(0, 1'b0, 5'd0); cycle_a();

    // Byte lanes on x5
    cur_tag = "x5_full"; wr(1'b0, 5'd5, 32'h11223344, 4'hF, 1'b0); cycle_a();
    cur_tag = "x5_lane0"; wr(1'b0, 5'd5, 32'h000000AA, 4'h1, 1'b0); cycle_a();
    cur_tag = "x5_rd1"; rd(0, 1'b0, 5'd5); cycle_a();
    cur_tag = "x5_lane23"; wr(1'b0, 5'd5, 32'h55660000, 4'hC, 1'b0); rd(1, 1'b0, 5'd5); cycle_a();
    cur_tag = "x5_rd2"; rd(0, 1'b0, 5'd5); rd(1, 1'b0, 5'd5); cycle_a();
    cur_tag = "x5_be0"; wr(1'b0, 5'd5, 32'hFFFFFFFF, 4'h0, 1'b0); rd(0, 1'b0, 5'd5); cycle_a();

    // Bypass and file separation
    cur_tag = "x7_wr"; wr(1'b0, 5'd7, 32'h77777777, 4'hF, 1'b0); cycle_a();
    cur_tag = "f7_byp"; wr(1'b1, 5'd7, 32'hCAFEF00D, 4'hF, 1'b0);
    rd(0, 1'b0, 5'd7); rd(1, 1'b1, 5'd7); cycle_a();

    // Scoreboard priority
    cur_tag = "sb_set9"; sb(1'b0, 5'd9); rd(0, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_hold9"; rd(0, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_setclr9"; sb(1'b0, 5'd9); wr(1'b0, 5'd9, 32'h00000009, 4'hF, 1'b1);
    rd(0, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_still9"; rd(1, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_clr9"; wr(1'b0, 5'd9, 32'h0, 4'h0, 1'b1); rd(0, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_flush9"; sb(1'b0, 5'd9); FLUSH = 1'b1; rd(0, 1'b0, 5'd9); cycle_a();
    cur_tag = "sb_x0"; sb(1'b0, 5'd0); rd(0, 1'b0, 5'd0); cycle_a();
    cur_tag = "sb_f0"; sb(1'b1, 5'd0); rd(1, 1'b1, 5'd0); cycle_a();
    cur_tag = "sb_f3"; sb(1'b1, 5'd3); rd(1, 1'b1, 5'd3); rd(0, 1'b0, 5'd3); cycle_a();
    cur_tag = "sb_f3_flush"; FLUSH = 1'b1; rd(1, 1'b1, 5'd3); cycle_a();

    // PC load and hold
    cur_tag = "pc_load"; PC_WE = 1'b1; PC_WDATA = 32'h00000100; cycle_a();
    cur_tag = "pc_hold"; PC_WDATA = 32'hFFFFFFFF; cycle_a();

    // Asynchronous reset in the middle of operation
    cur_tag = "x3_setup"; wr(1'b0, 5'd3, 32'h12345678, 4'hF, 1'b0); sb(1'b0, 5'd3);
    rd(0, 1'b0, 5'd3); rd(1, 1'b0, 5'd3); cycle_a();
    #2;
    RST = 1'b1;
    #1;
    check_eq("midrst.pc", {32'd0, PC}, 64'd0);
    check_eq("midrst.rdata", R_DATA, 64'd0);
    check_eq("midrst.rbusy", {62'd0, R_BUSY}, 64'd0);
    model_reset();
    RST = 1'b0;
    cur_tag = "x3_after"; rd(0, 1'b0, 5'd3); cycle_a();

    // Swept configuration: 64-bit, 16 registers, 3 ports, real f0
    b_w_valid = 1'b1; b_w_fp = 1'b0; b_w_addr = 4'd15; b_w_data = 64'hFEDCBA9876543210; b_w_be = 8'hFF;
    @(posedge CLK); #1; idle_b();
    b_w_valid = 1'b1; b_w_fp = 1'b0; b_w_addr = 4'd0; b_w_data = 64'hFFFFFFFFFFFFFFFF; b_w_be = 8'hFF;
    @(posedge CLK); #1; idle_b();
    b_w_valid = 1'b1; b_w_fp = 1'b1; b_w_addr = 4'd0; b_w_data = 64'h0123456789ABCDEF; b_w_be = 8'hFF;
    b_r_fp = 3'b010; b_r_addr = {4'd0, 4'd0, 4'd0};
    push("b.f0_byp", 64'h0123456789ABCDEF);
    @(posedge CLK); #1; idle_b();
    pop_check(b_r_data[127:64]);
    b_sb_set = 1'b1; b_sb_fp = 1'b1; b_sb_addr = 4'd0;
    b_r_fp = 3'b010; b_r_addr = {4'd0, 4'd0, 4'd15};
    push("b.p0.x15", 64'hFEDCBA9876543210);
    push("b.p1.f0", 64'h0123456789ABCDEF);
    push("b.p2.x0", 64'd0);
    push("b.busy", 64'd2);
    @(posedge CLK); #1; idle_b();
    pop_check(b_r_data[63:0]);
    pop_check(b_r_data[127:64]);
    pop_check(b_r_data[191:128]);
    pop_check({61'd0, b_r_busy});

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_regbank.md
# core_regbank

Parametrised integer/FP architectural register bank for the core. It replaces the fixed 32x32 two-file design with configurable width, depth and read-port count, adds byte-lane writes, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode (read ports, issue) and writeback/IO (write port), and it also holds the PC.

## Interface
Parameters:
- XLEN, 32: register width in bits. Must be a multiple of 8.
- NREG, 32: registers per file. Must be a power of 2 and at least 2. AW = log2(NREG).
- NRP, 2: read ports. Each port can address either file.
- F0_ZERO, 1: when 1, FP register 0 is hardwired to zero like x0. When 0, f0 is a real register.

Ports (LANES = XLEN/8):
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- W_VALID  in  1  write strobe.
- W_FP  in  1  write file select: 0 = integer, 1 = FP.
- W_ADDR  in  AW  write register index.
- W_DATA  in  XLEN  write data.
- W_BE  in  LANES  byte-lane enables for the write.
- W_DONE  in  1  when set with W_VALID, this write is the final one and clears the busy bit.
- SB_SET  in  1  issue strobe: mark the destination register busy.
- SB_FP  in  1  issue file select.
- SB_ADDR  in  AW  issue register index.
- FLUSH  in  1  clear all busy bits in both files.
- R_FP  in  NRP  per-port file select.
- R_ADDR  in  NRP*AW  per-port register index; port p uses slice [p*AW +: AW].
- R_DATA  out  NRP*XLEN  per-port read data, registered.
- R_BUSY  out  NRP  per-port busy status, registered.
- PC_WE  in  1  PC write enable.
- PC_WDATA  in  XLEN  next PC value.
- PC  out  XLEN  program counter, registered.

## Operation
- Storage: two files of NREG x XLEN, integer and FP.
- Hardwired zeros: x0 always reads 0. f0 reads 0 when F0_ZERO=1. Writes to a hardwired register are dropped, and SB_SET never makes it busy.
- Write: when W_VALID=1, lane i of the target register takes W_DATA[8i+7:8i] where W_BE[i]=1; other lanes hold. W_BE=0 is a legal no-op write, but W_DONE still applies.
- Scoreboard: one busy bit per register per file.
  - SB_SET sets the busy bit of (SB_FP, SB_ADDR).
  - W_VALID&W_DONE clears the busy bit of (W_FP, W_ADDR).
  - Priority: FLUSH > SB_SET > clear. A set and a clear of the same register in one cycle leave it busy, because a new producer was issued.
- Read: at each edge, R_DATA[p] takes the next-state value of the addressed register, i.e. the stored value with any same-cycle write lanes merged in (bypass). R_BUSY[p] likewise takes the next-state busy bit.
- PC: loads PC_WDATA when PC_WE=1, otherwise holds.

## Timing
- Read latency is 1 cycle: an address presented in cycle t gives data and busy on the outputs after edge t+1.
- A write in cycle t is visible to a read issued in cycle t (bypass) and to any later read.
- Busy set or cleared in cycle t is visible to a read issued in cycle t.
- Reset (asynchronous, any time, including mid-write) forces all of the following to 0 immediately: all registers, all busy bits, R_DATA, R_BUSY, PC. The first post-reset edge behaves normally.
- All read ports are independent. Multiple ports may address the same register and return identical values.

## Structure
- Package core_regbank_pkg holds:
  - XLEN default.
  - The AW derivation function.
  - File-select constants FILE_INT=1'b0 and FILE_FP=1'b1.
- Sub-module core_regbank_file: one instance per file (integer with zero-reg forced, FP with zero-reg governed by F0_ZERO). Each instance holds storage plus busy bits, applies lane-merged writes and set/clear/flush, and exposes combinational next-state data and busy for NRP addresses.
- The top contains:
  - Per-port file-select mux.
  - Output registers R_DATA and R_BUSY.
  - PC register.

## Test plan
- Reset and zero registers: after reset, read x0..x31 and f1 on port 0 -> R_DATA=0 and R_BUSY=0 for all. Write x0=0xDEADBEEF with W_BE=4'hF -> x0 still reads 0.
- Byte lanes: write x5=0x11223344 with BE=4'hF, then W_DATA=0x000000AA with BE=4'h1 -> x5 reads 0x112233AA. Then BE=4'hC with W_DATA=0x55660000 -> x5 reads 0x556633AA.
- Bypass: in one cycle, write f7=0xCAFEF00D and read f7 on port 1 -> R_DATA port 1 = 0xCAFEF00D one edge later. In the same cycle, port 0 reads x7 -> the old x7 value, showing the files are separate.
- Scoreboard priority:
  - SB_SET x9 -> R_BUSY=1 on a following read.
  - Write x9 with W_DONE=1 while SB_SET x9 in the same cycle -> still busy.
  - A later W_DONE write to x9 -> busy 0.
  - SB_SET and FLUSH in the same cycle -> busy 0.
- Reset mid-operation: with x3=0x12345678 busy and PC=0x100, assert RST between edges -> PC, R_DATA and R_BUSY drop to 0 without a clock edge. After release, x3 reads 0 and is not busy.
- Parameter sweep: XLEN=64, NREG=16, NRP=3, F0_ZERO=0 -> f0 write of 0x0123456789ABCDEF reads back exactly, and three ports reading x15/f0/x0 return stored/stored/0.
